// File: rtl/axis_pulse_seq_if.sv
// AXI-Stream bundle carrying sample beats out of the pulse sequencer.
interface axis_pulse_seq_if #(
  parameter int DATA_WIDTH = 16,
  parameter int SPC        = 4
);
  logic [SPC*DATA_WIDTH-1:0] tdata;
  logic                      tvalid;
  logic                      tready;
  logic                      tlast;

  modport master (output tdata, tvalid, tlast, input tready);
  modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_pulse_seq.sv
// Periodic / triggered-burst rectangular pulse generator on an AXIS beat stream.
// Beat 0 appears two edges after a trigger edge; a stall (tready=0) freezes outputs and progress.
module axis_pulse_seq #(
  parameter int DATA_WIDTH = 16,
  parameter int SPC        = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [1:0]            cfg_mode,
  input  logic [CNT_WIDTH-1:0]  cfg_period,
  input  logic [CNT_WIDTH-1:0]  cfg_width,
  input  logic [DATA_WIDTH-1:0] cfg_amplitude,
  input  logic [CNT_WIDTH-1:0]  cfg_burst,
  input  logic                  trig_in,
  axis_pulse_seq_if.master      m_axis,
  output logic                  busy
);
  localparam int IW = CNT_WIDTH + $clog2(SPC);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN} state_t;

  state_t                    state_q, state_d;
  logic [CNT_WIDTH-1:0]      beat_q, beat_d;
  logic [CNT_WIDTH-1:0]      burst_cnt_q, burst_cnt_d;
  logic [CNT_WIDTH-1:0]      period_q, period_d;
  logic [CNT_WIDTH-1:0]      width_q, width_d;
  logic [CNT_WIDTH-1:0]      burst_q, burst_d;
  logic [DATA_WIDTH-1:0]     amp_q, amp_d;
  logic                      trig_q, trig_d;
  logic                      burst_mode_q, burst_mode_d;
  logic [SPC*DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                      tlast_q, tlast_d;
  logic                      tvalid_q, tvalid_d;
  logic                      busy_q, busy_d;

  logic [SPC*DATA_WIDTH-1:0] beat_dat;
  logic [CNT_WIDTH-1:0]      period_eff, burst_eff;
  logic                      trig_edge, last_beat, burst_done, latch_cfg;

  assign period_eff = (cfg_period == '0) ? CNT_ONE : cfg_period;
  assign burst_eff  = (cfg_burst == '0) ? CNT_ONE : cfg_burst;
  assign trig_edge  = trig_in & ~trig_q;
  assign last_beat  = (beat_q == period_q - CNT_ONE);
  assign burst_done = (burst_cnt_q >= burst_q - CNT_ONE);

  // Sample index is widened so beat*SPC never wraps before the width compare.
  always_comb begin
    beat_dat = '0;
    for (int i = 0; i < SPC; i++) begin
      if ((IW'(beat_q) * IW'(SPC) + IW'(i)) < IW'(width_q))
        beat_dat[i*DATA_WIDTH +: DATA_WIDTH] = amp_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    burst_cnt_d  = burst_cnt_q;
    period_d     = period_q;
    width_d      = width_q;
    burst_d      = burst_q;
    amp_d        = amp_q;
    burst_mode_d = burst_mode_q;
    tdata_d      = tdata_q;
    tlast_d      = tlast_q;
    trig_d       = trig_in;
    tvalid_d     = 1'b1;
    latch_cfg    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (m_axis.tready) begin
          tdata_d = '0;
          tlast_d = 1'b0;
        end
        if (cfg_mode == 2'd1) begin
          state_d      = S_RUN;
          latch_cfg    = 1'b1;
          burst_mode_d = 1'b0;
          beat_d       = '0;
          burst_cnt_d  = '0;
        end else if (cfg_mode == 2'd2) begin
          state_d = S_ARMED;
        end
      end

      S_ARMED: begin
        if (m_axis.tready) begin
          tdata_d = '0;
          tlast_d = 1'b0;
        end
        if (cfg_mode != 2'd2) begin
          state_d = S_IDLE;
        end else if (trig_edge) begin
          state_d      = S_RUN;
          latch_cfg    = 1'b1;
          burst_mode_d = 1'b1;
          burst_d      = burst_eff;
          beat_d       = '0;
          burst_cnt_d  = '0;
        end
      end

      S_RUN: begin
        if (m_axis.tready) begin
          tdata_d = beat_dat;
          tlast_d = last_beat;
          if (!last_beat) begin
            beat_d = beat_q + CNT_ONE;
          end else begin
            beat_d = '0;
            if (!burst_mode_q) begin
              if (cfg_mode == 2'd1) latch_cfg = 1'b1;
              else                  state_d   = S_IDLE;
            end else if (burst_done) begin
              burst_cnt_d = '0;
              state_d     = (cfg_mode == 2'd2) ? S_ARMED : S_IDLE;
            end else begin
              burst_cnt_d = burst_cnt_q + CNT_ONE;
              latch_cfg   = 1'b1;
            end
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (latch_cfg) begin
      period_d = period_eff;
      width_d  = cfg_width;
      amp_d    = cfg_amplitude;
    end
    busy_d = (state_d == S_RUN);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= S_IDLE;
      beat_q       <= '0;
      burst_cnt_q  <= '0;
      period_q     <= '0;
      width_q      <= '0;
      burst_q      <= '0;
      amp_q        <= '0;
      trig_q       <= 1'b0;
      burst_mode_q <= 1'b0;
      tdata_q      <= '0;
      tlast_q      <= 1'b0;
      tvalid_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      burst_cnt_q  <= burst_cnt_d;
      period_q     <= period_d;
      width_q      <= width_d;
      burst_q      <= burst_d;
      amp_q        <= amp_d;
      trig_q       <= trig_d;
      burst_mode_q <= burst_mode_d;
      tdata_q      <= tdata_d;
      tlast_q      <= tlast_d;
      tvalid_q     <= tvalid_d;
      busy_q       <= busy_d;
    end
  end

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;
  assign busy          = busy_q;
endmodule
